// File: rtl/fpu_req_ctrl_pkg.sv
// fpu_req_ctrl_pkg: shared constants, opcodes and state encoding for the FPU request controller.
package fpu_req_ctrl_pkg;
  localparam int FORMAT_LENGTH = 32;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SQRT = 3'b100;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SQRT;
  endfunction
endpackage

// File: rtl/fpu_req_ctrl_stat_counters.sv
// fpu_stat_counters: wrapping completed-op counter and saturating exception counter.
module fpu_stat_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             exc,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] exc_count
);
  import fpu_req_ctrl_pkg::*;
  logic [CNT_W-1:0] op_q, op_d, exc_q, exc_d;
  always_comb begin
    op_d  = en ? op_q + CNT_W'(1) : op_q;
    exc_d = (en && exc && !(&exc_q)) ? exc_q + CNT_W'(1) : exc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      exc_q <= '0;
    end else begin
      op_q  <= op_d;
      exc_q <= exc_d;
    end
  end
  assign op_count  = op_q;
  assign exc_count = exc_q;
endmodule

// File: rtl/fpu_req_ctrl.sv
// fpu_req_ctrl: valid/ready front end that launches operands on a combinational FPU core,
// waits a fixed settle time, and returns the captured result and flags.
module fpu_req_ctrl #(
  parameter int FORMAT_LENGTH = fpu_req_ctrl_pkg::FORMAT_LENGTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int TAG_W         = 4,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [FORMAT_LENGTH-1:0] req_op_a,
  input  logic [FORMAT_LENGTH-1:0] req_op_b,
  input  logic [2:0]               req_operation,
  input  logic [TAG_W-1:0]         req_tag,
  output logic [FORMAT_LENGTH-1:0] fpu_op_a,
  output logic [FORMAT_LENGTH-1:0] fpu_op_b,
  output logic [2:0]               fpu_operation,
  input  logic [FORMAT_LENGTH-1:0] fpu_result,
  input  logic                     fpu_overflow,
  input  logic                     fpu_underflow,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [FORMAT_LENGTH-1:0] resp_result,
  output logic                     resp_overflow,
  output logic                     resp_underflow,
  output logic                     resp_illegal,
  output logic [TAG_W-1:0]         resp_tag,
  output logic [CNT_W-1:0]         op_count,
  output logic [CNT_W-1:0]         exc_count
);
  import fpu_req_ctrl_pkg::*;
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("fpu_req_ctrl: SETTLE_CYCLES must be in 1..15");
  end
  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [FORMAT_LENGTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]               op_q, op_d;
  logic [TAG_W-1:0]         tag_q, tag_d, rtag_q, rtag_d;
  logic                     ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ill_d   = ill_q;
    rtag_d  = rtag_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        tag_d = req_tag;
        // illegal opcodes never reach the core; answer with a quiet NaN at once
        if (op_legal(req_operation)) begin
          a_d     = req_op_a;
          b_d     = req_op_b;
          op_d    = req_operation;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end else begin
          res_d   = FORMAT_LENGTH'(QNAN);
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          ill_d   = 1'b1;
          rtag_d  = req_tag;
          state_d = S_RESP;
        end
      end
      S_SETTLE: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        res_d   = fpu_result;
        ovf_d   = fpu_overflow;
        unf_d   = fpu_underflow;
        ill_d   = 1'b0;
        rtag_d  = tag_q;
        state_d = S_RESP;
      end
      S_RESP: state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ill_q   <= ill_d;
      rtag_q  <= rtag_d;
    end
  end
  assign req_ready      = state_q == S_IDLE;
  assign resp_valid     = state_q == S_RESP;
  assign fpu_op_a       = a_q;
  assign fpu_op_b       = b_q;
  assign fpu_operation  = op_q;
  assign resp_result    = res_q;
  assign resp_overflow  = ovf_q;
  assign resp_underflow = unf_q;
  assign resp_illegal   = ill_q;
  assign resp_tag       = rtag_q;
  fpu_stat_counters #(.CNT_W(CNT_W)) u_stats (
    .clk       (clk),
    .rst       (rst),
    .en        (resp_valid && resp_ready),
    .exc       (ovf_q || unf_q || ill_q),
    .op_count  (op_count),
    .exc_count (exc_count)
  );
endmodule

// File: tb/tb_fpu_req_ctrl.sv
// tb_fpu_req_ctrl: directed and random requests against a stand-in combinational core,
// checked with a transaction-level model of the controller's responses and counters.
module tb_fpu_req_ctrl;
  localparam int FL = 32;
  localparam int SC = 2;
  localparam int TW = 4;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [FL-1:0] req_op_a, req_op_b;
  logic [2:0]    req_operation;
  logic [TW-1:0] req_tag;
  logic [FL-1:0] fpu_op_a, fpu_op_b, fpu_result;
  logic [2:0]    fpu_operation;
  logic          fpu_overflow, fpu_underflow;
  logic          resp_valid, resp_ready;
  logic [FL-1:0] resp_result;
  logic          resp_overflow, resp_underflow, resp_illegal;
  logic [TW-1:0] resp_tag;
  logic [CW-1:0] op_count, exc_count;
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_ops = '0;
  logic [CW-1:0] exp_exc = '0;
  logic [FL-1:0] last_a = '0, last_b = '0;
  logic [2:0]    last_op = '0;

  fpu_req_ctrl #(.FORMAT_LENGTH(FL), .SETTLE_CYCLES(SC), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_operation(req_operation), .req_tag(req_tag),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_underflow(resp_underflow), .resp_illegal(resp_illegal),
    .resp_tag(resp_tag), .op_count(op_count), .exc_count(exc_count)
  );

  // stand-in core: arbitrary but deterministic result, flags keyed on operand A's exponent
  function automatic logic [33:0] core_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] r;
    r = (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
    return {a[30:23] == 8'hFE, a[30:23] == 8'h01, r};
  endfunction
  assign {fpu_overflow, fpu_underflow, fpu_result} = core_fn(fpu_op_a, fpu_op_b, fpu_operation);

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [3:0] tag, input int nwait);
    logic [33:0] er;
    logic        ill;
    int          lat, guard;
    ill = op > 3'd4;
    er  = ill ? {2'b00, 32'h7FC0_0000} : core_fn(a, b, op);
    lat = ill ? 1 : SC + 1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_accept", req_ready, 1);
    req_valid = 1; req_op_a = a; req_op_b = b; req_operation = op; req_tag = tag;
    tick();
    req_op_a = $urandom; req_op_b = $urandom; req_operation = 3'($urandom); req_tag = 4'($urandom);
    for (int k = 1; k < lat; k++) begin
      chk("settle_valid", resp_valid, 0);
      chk("settle_ready", req_ready, 0);
      chk("settle_fpu_a", fpu_op_a, a);
      chk("settle_fpu_b", fpu_op_b, b);
      chk("settle_fpu_op", fpu_operation, op);
      tick();
    end
    if (!ill) begin
      last_a = a; last_b = b; last_op = op;
    end
    chk("resp_valid_latency", resp_valid, 1);
    chk("resp_result", resp_result, er[31:0]);
    chk("resp_overflow", resp_overflow, er[33]);
    chk("resp_underflow", resp_underflow, er[32]);
    chk("resp_illegal", resp_illegal, ill);
    chk("resp_tag", resp_tag, tag);
    chk("fpu_a_at_resp", fpu_op_a, last_a);
    chk("fpu_b_at_resp", fpu_op_b, last_b);
    chk("fpu_op_at_resp", fpu_operation, last_op);
    for (int w = 0; w < nwait; w++) begin
      tick();
      chk("hold_valid", resp_valid, 1);
      chk("hold_ready", req_ready, 0);
      chk("hold_result", resp_result, er[31:0]);
      chk("hold_tag", resp_tag, tag);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0; req_valid = 0;
    exp_ops = exp_ops + 1'b1;
    if ((ill || er[33] || er[32]) && exp_exc != '1) exp_exc = exp_exc + 1'b1;
    chk("post_hs_valid", resp_valid, 0);
    chk("post_hs_ready", req_ready, 1);
    chk("post_hs_result_kept", resp_result, er[31:0]);
    chk("op_count", op_count, exp_ops);
    chk("exc_count", exc_count, exp_exc);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    rst = 1; req_valid = 0; req_op_a = 0; req_op_b = 0; req_operation = 0; req_tag = 0; resp_ready = 0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_flags", {resp_overflow, resp_underflow, resp_illegal}, 0);
    chk("rst_fpu_a", fpu_op_a, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_exc_count", exc_count, 0);
    rst = 0;
    tick();
    do_req(32'h3F00_0000, 32'h3EB0_0000, 3'b000, 4'd5, 0);
    do_req(32'h3EB0_0000, 32'h3F00_0000, 3'b001, 4'd9, 6);
    do_req(32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000, 4'd1, 1);
    do_req(32'h0080_0030, 32'h0080_0005, 3'b001, 4'd2, 0);
    do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b110, 4'd3, 2);
    // reset while the operation is still settling
    req_valid = 1; req_op_a = 32'h4000_0000; req_op_b = 32'h4040_0000; req_operation = 3'b010; req_tag = 4'd7;
    tick();
    req_valid = 0;
    tick();
    #2 rst = 1;
    #1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_exc_count", exc_count, 0);
    chk("midrst_fpu_a", fpu_op_a, 0);
    rst = 0;
    exp_ops = '0; exp_exc = '0; last_a = '0; last_b = '0; last_op = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_resp", resp_valid, 0);
    end
    do_req(32'h4000_0000, 32'h4040_0000, 3'b010, 4'd7, 0);
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: ra[30:23] = 8'hFE;
        1: ra[30:23] = 8'h01;
        default: ;
      endcase
      do_req(ra, rb, rop, 4'(i), $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
